// File: rtl/aes_encipher_iter.sv
// Iterative AES-128/256 encipher: one round per clock, round keys supplied
// combinationally by an external key memory indexed by the round output.
module aes_encipher_iter (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    input  logic [127:0] block,
    input  logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         ready,
    output logic [127:0] new_block,
    output logic         valid
);
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned ROUND_W = 4;

    typedef enum logic [1:0] {IDLE, INIT, MAIN, FINAL} fsm_e;

    fsm_e                 fsm_q, fsm_d;
    logic [BLOCK_W-1:0]   state_q, state_d;
    logic [BLOCK_W-1:0]   new_block_q, new_block_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic                 keylen_q, keylen_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;
    logic [BLOCK_W-1:0]   sub_c;
    logic [ROUND_W-1:0]   last_main_c;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // Byte (row w, column c) lives at bits [127-8*(4c+w) -: 8]; row w rotates left by w.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    // SubBytes shared by MAIN and FINAL
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (state_q[127 - 8*i -: 8]),
            .out_byte (sub_c[127 - 8*i -: 8])
        );
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        new_block_d = new_block_q;
        round_d     = round_q;
        keylen_d    = keylen_q;
        ready_d     = ready_q;
        valid_d     = valid_q;
        last_main_c = keylen_q ? 4'd13 : 4'd9;

        case (fsm_q)
            IDLE: begin
                round_d = '0;
                if (next) begin
                    state_d  = block;
                    keylen_d = keylen;
                    valid_d  = 1'b0;
                    ready_d  = 1'b0;
                    fsm_d    = INIT;
                end
            end
            INIT: begin
                state_d = state_q ^ round_key;
                round_d = 4'd1;
                fsm_d   = MAIN;
            end
            MAIN: begin
                state_d = mix_columns(shift_rows(sub_c)) ^ round_key;
                round_d = round_q + 4'd1;
                if (round_q == last_main_c) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                new_block_d = shift_rows(sub_c) ^ round_key;
                valid_d     = 1'b1;
                ready_d     = 1'b1;
                round_d     = '0;
                fsm_d       = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            new_block_q <= '0;
            round_q     <= '0;
            keylen_q    <= 1'b0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            new_block_q <= new_block_d;
            round_q     <= round_d;
            keylen_q    <= keylen_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
        end
    end

    assign round     = round_q;
    assign ready     = ready_q;
    assign new_block = new_block_q;
    assign valid     = valid_q;
endmodule

// AES S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    logic [7:0] sq;
    logic [7:0] inv;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    always_comb begin
        sq  = in_byte;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// File: tb/tb_aes_encipher_iter.sv
// Scoreboard bench for aes_encipher_iter against a table-driven AES model.
module tb_aes_encipher_iter;
    logic         clk = 1'b0;
    logic         reset;
    logic         next;
    logic         keylen;
    logic [127:0] block;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic         ready;
    logic [127:0] new_block;
    logic         valid;

    always #5 clk = ~clk;

    aes_encipher_iter dut (
        .clk       (clk),
        .reset     (reset),
        .next      (next),
        .keylen    (keylen),
        .block     (block),
        .round_key (round_key),
        .round     (round),
        .ready     (ready),
        .new_block (new_block),
        .valid     (valid)
    );

    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [7:0]   gexp [256];
    logic [7:0]   glog [256];
    logic [127:0] rk_mem [16];

    assign round_key = rk_mem[round];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] pt;
        logic [255:0] key;
        logic         kl;
        int           issue;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(int'(glog[a]) + int'(glog[b])) % 255];
    endfunction

    // Exp/log tables over generator 3, then inverse + affine map for the S-box.
    task automatic build_tables();
        logic [7:0] x;
        logic [7:0] inv;
        logic [7:0] s;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = 8'(i);
            x = x ^ xt(x);
        end
        gexp[255] = gexp[0];
        glog[0]   = 8'h00;
        for (int a = 0; a < 256; a++) begin
            inv = (a == 0) ? 8'h00 : gexp[(255 - int'(glog[a])) % 255];
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[a]  = s;
            isbox[s] = 8'(a);
        end
    endtask

    // Round keys packed as ks[128*r +: 128]; AES-128 keys sit in key[255:128].
    function automatic logic [1919:0] key_sched(input logic [255:0] key, input logic kl);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] res;
        int nk;
        int nr;
        nk   = kl ? 8 : 4;
        nr   = kl ? 14 : 10;
        rcon = 8'h01;
        res  = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk == 8 && i % nk == 4) begin
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j <= nr; j++) res[128*j +: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        return res;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] ks, input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] rk;
        logic [127:0] out;
        rk = ks[127:0];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ rk[127 - 8*(4*c + r) -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            rk = ks[128*rnd +: 128];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox[s[r][(c + r) % 4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = ((rnd < nr) ? (gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                                             ^ t[(r+2)%4][c] ^ t[(r+3)%4][c]) : t[r][c])
                            ^ rk[127 - 8*(4*c + r) -: 8];
        end
        out = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                out[127 - 8*(4*c + r) -: 8] = s[r][c];
        return out;
    endfunction

    function automatic logic [127:0] decrypt(input logic [127:0] ct, input logic [1919:0] ks, input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] rk;
        logic [127:0] out;
        rk = ks[128*nr +: 128];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[127 - 8*(4*c + r) -: 8] ^ rk[127 - 8*(4*c + r) -: 8];
        for (int rnd = nr - 1; rnd >= 0; rnd--) begin
            rk = ks[128*rnd +: 128];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = isbox[s[r][(c - r + 4) % 4]] ^ rk[127 - 8*(4*c + r) -: 8];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = (rnd > 0) ? (gmul(8'h0e, t[r][c]) ^ gmul(8'h0b, t[(r+1)%4][c])
                                           ^ gmul(8'h0d, t[(r+2)%4][c]) ^ gmul(8'h09, t[(r+3)%4][c]))
                                        : t[r][c];
        end
        out = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                out[127 - 8*(4*c + r) -: 8] = s[r][c];
        return out;
    endfunction

    task automatic load_keys(input logic [255:0] key, input logic kl);
        logic [1919:0] ks;
        ks = key_sched(key, kl);
        for (int j = 0; j < 15; j++) rk_mem[j] = ks[128*j +: 128];
        rk_mem[15] = '0;
    endtask

    task automatic push_exp(input logic [127:0] pt, input logic [255:0] key, input logic kl,
                            input logic [127:0] kat, input logic use_kat);
        exp_t e;
        e.pt    = pt;
        e.key   = key;
        e.kl    = kl;
        e.issue = cyc;
        e.ct    = use_kat ? kat : encrypt(pt, key_sched(key, kl), kl ? 14 : 10);
        exp_q.push_back(e);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (ready !== 1'b1) chk("ready_timeout", 128'(ready), 128'(1));
    endtask

    // Start one block, then scramble block/keylen once it has been captured.
    task automatic issue(input logic [127:0] pt, input logic [255:0] key, input logic kl,
                         input logic [127:0] kat, input logic use_kat);
        wait_ready();
        load_keys(key, kl);
        push_exp(pt, key, kl, kat, use_kat);
        block  = pt;
        keylen = kl;
        next   = 1'b1;
        @(posedge clk); #1;
        next   = 1'b0;
        block  = {$urandom, $urandom, $urandom, $urandom};
        keylen = 1'($urandom);
    endtask

    // Monitor: each rising valid pops one expectation.
    initial begin
        logic          prev_v;
        exp_t          e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (valid === 1'b1 && prev_v !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 128'(valid), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("ciphertext", new_block, e.ct);
                    chk("latency", 128'(cyc - e.issue), 128'(e.kl ? 16 : 12));
                    chk("ready_with_valid", 128'(ready), 128'(1));
                    chk("decipher", decrypt(new_block, key_sched(e.key, e.kl), e.kl ? 14 : 10), e.pt);
                end
            end
            prev_v = valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [255:0] key;
        logic         kl;
        int           n;
        build_tables();
        for (int j = 0; j < 16; j++) rk_mem[j] = '0;
        reset  = 1'b1;
        next   = 1'b0;
        keylen = 1'b0;
        block  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 128'(ready), 128'(1));
        chk("reset_valid", 128'(valid), 128'(0));
        chk("reset_round", 128'(round), 128'(0));
        chk("reset_new_block", new_block, 128'h0);
        reset = 1'b0;

        // First cycle out of reset accepts next
        issue(PT_C, KEY_C1, 1'b0, CT_C1, 1'b1);

        // AES-256 with the round index sequence 0..14 then back to 0
        wait_ready();
        issue(PT_C, KEY_C3, 1'b1, CT_C3, 1'b1);
        chk("round_after_capture", 128'(round), 128'(0));
        for (int j = 1; j <= 14; j++) begin
            @(posedge clk); #1;
            chk("round_seq", 128'(round), 128'(j));
        end
        @(posedge clk); #1;
        chk("round_idle", 128'(round), 128'(0));
        chk("ready_done", 128'(ready), 128'(1));

        issue(PT_B, KEY_B, 1'b0, CT_B, 1'b1);

        // next held high with block/keylen toggling; second block follows ready
        wait_ready();
        load_keys(KEY_C1, 1'b0);
        push_exp(PT_C, KEY_C1, 1'b0, CT_C1, 1'b1);
        block  = PT_C;
        keylen = 1'b0;
        next   = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            chk("busy_while_held", 128'(ready), 128'(0));
            block  = {$urandom, $urandom, $urandom, $urandom};
            keylen = ~keylen;
        end
        block  = PT_B;
        keylen = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ready !== 1'b1 && n < 100);
        chk("held_ready", 128'(ready), 128'(1));
        load_keys(KEY_B, 1'b0);
        push_exp(PT_B, KEY_B, 1'b0, CT_B, 1'b1);
        @(posedge clk); #1;
        chk("back_to_back_start", 128'(ready), 128'(0));
        next = 1'b0;

        // Abort an AES-128 block with reset at cycle 5
        issue(PT_C, KEY_C1, 1'b0, CT_C1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("abort_ready", 128'(ready), 128'(1));
        chk("abort_valid", 128'(valid), 128'(0));
        chk("abort_round", 128'(round), 128'(0));
        chk("abort_new_block", new_block, 128'h0);
        reset = 1'b0;
        issue(PT_C, KEY_C1, 1'b0, CT_C1, 1'b1);

        // Random blocks and keys of both lengths
        for (int i = 0; i < 1000; i++) begin
            kl  = 1'($urandom);
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (!kl) key[127:0] = '0;
            issue({$urandom, $urandom, $urandom, $urandom}, key, kl, 128'h0, 1'b0);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
